idex_pipe: RTL and testbench

IDEX_PIPE -- requirements
Module: idex_pipe

---
 rtl/idex_pipe_if.sv | 57 +++++
 rtl/idex_pipe.sv | 165 ++++++++++++++++
 tb/tb_idex_pipe.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idex_pipe_if.sv
// ID/EX pipeline-register bus: ID offer, EX presentation, flush and WB retire port.
// The pipe register takes the slave side; the surrounding core drives the master side.
interface idex_pipe_if;
    // ID side
    logic        id_i_valid;
    logic [63:0] id_i_pc;
    logic [31:0] id_i_insn;
    logic [4:0]  id_i_rs1;
    logic [4:0]  id_i_rs2;
    logic        id_i_rs1_re;
    logic        id_i_rs2_re;
    logic [4:0]  id_i_rd;
    logic        id_i_rf_we;
    logic        id_i_is_load;
    logic [63:0] id_i_rs1_dat;
    logic [63:0] id_i_rs2_dat;
    logic        id_o_ready;

    // EX side
    logic        ex_o_valid;
    logic [63:0] ex_o_pc;
    logic [31:0] ex_o_insn;
    logic [4:0]  ex_o_rs1;
    logic [4:0]  ex_o_rs2;
    logic [4:0]  ex_o_rd;
    logic        ex_o_rf_we;
    logic        ex_o_is_load;
    logic [63:0] ex_o_rs1_dat;
    logic [63:0] ex_o_rs2_dat;
    logic        ex_i_ready;

    // control and writeback retire port
    logic        flush;
    logic [4:0]  wb_i_rd;
    logic        wb_i_rf_we;
    logic [63:0] wb_i_rd_dat;

    modport master (
        output id_i_valid, id_i_pc, id_i_insn, id_i_rs1, id_i_rs2,
               id_i_rs1_re, id_i_rs2_re, id_i_rd, id_i_rf_we, id_i_is_load,
               id_i_rs1_dat, id_i_rs2_dat,
               ex_i_ready, flush, wb_i_rd, wb_i_rf_we, wb_i_rd_dat,
        input  id_o_ready,
               ex_o_valid, ex_o_pc, ex_o_insn, ex_o_rs1, ex_o_rs2, ex_o_rd,
               ex_o_rf_we, ex_o_is_load, ex_o_rs1_dat, ex_o_rs2_dat
    );

    modport slave (
        input  id_i_valid, id_i_pc, id_i_insn, id_i_rs1, id_i_rs2,
               id_i_rs1_re, id_i_rs2_re, id_i_rd, id_i_rf_we, id_i_is_load,
               id_i_rs1_dat, id_i_rs2_dat,
               ex_i_ready, flush, wb_i_rd, wb_i_rf_we, wb_i_rd_dat,
        output id_o_ready,
               ex_o_valid, ex_o_pc, ex_o_insn, ex_o_rs1, ex_o_rs2, ex_o_rd,
               ex_o_rf_we, ex_o_is_load, ex_o_rs1_dat, ex_o_rs2_dat
    );
endinterface

// File: rtl/idex_pipe.sv
// ID/EX pipeline register with load-use stall, flush and WB refresh of held operands.
// Optional IDEX_STALL_CNT_EN adds o_stall_cnt, a saturating load-use stall counter.
module idex_pipe (
    input  logic        clk,
    input  logic        rst,
    idex_pipe_if.slave  bus
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [31:0] o_stall_cnt
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [63:0] pc_reg;
    logic [31:0] insn_reg;
    logic [4:0]  rs1_reg;
    logic [4:0]  rs2_reg;
    logic [4:0]  rd_reg;
    logic        rf_we_reg;
    logic        is_load_reg;

    logic        full;
    logic        hazard;
    logic        ready;
    logic        accept;
    logic [1:0]  src_dep;
    logic [1:0]  src_hit;
    logic [1:0]  id_src_re;
    logic [4:0]  id_src_idx [2];
    logic [63:0] id_src_dat [2];
    logic [4:0]  ex_src_idx [2];
    logic [63:0] ex_src_dat [2];

    assign full = (state_reg == ST_FULL);

    assign id_src_re[0]  = bus.id_i_rs1_re;
    assign id_src_re[1]  = bus.id_i_rs2_re;
    assign id_src_idx[0] = bus.id_i_rs1;
    assign id_src_idx[1] = bus.id_i_rs2;
    assign id_src_dat[0] = bus.id_i_rs1_dat;
    assign id_src_dat[1] = bus.id_i_rs2_dat;
    assign ex_src_idx[0] = rs1_reg;
    assign ex_src_idx[1] = rs2_reg;

    // A held load whose result an offered source needs cannot forward yet: stall ID.
    assign hazard = full & is_load_reg & rf_we_reg & (rd_reg != 5'd0) & (|src_dep);
    assign ready  = (~full | bus.ex_i_ready) & ~hazard & ~bus.flush;
    assign accept = bus.id_i_valid & ready;

    // Per-source dependency check and operand storage with WB refresh while held.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [63:0] dat_reg;

            assign src_dep[gi] = id_src_re[gi] & (id_src_idx[gi] == rd_reg);

            // A held operand would otherwise go stale when its producer retires meanwhile.
            assign src_hit[gi] = full & ~bus.ex_i_ready & ~bus.flush & ~accept
                               & bus.wb_i_rf_we & (bus.wb_i_rd != 5'd0)
                               & (bus.wb_i_rd == ex_src_idx[gi]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    dat_reg <= '0;
                end else if (accept) begin
                    dat_reg <= id_src_dat[gi];
                end else if (src_hit[gi]) begin
                    dat_reg <= bus.wb_i_rd_dat;
                end
            end

            assign ex_src_dat[gi] = dat_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.flush) begin
                    state_next = ST_EMPTY;
                end else if (accept) begin
                    state_next = ST_FULL;
                end else if (bus.ex_i_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Payload is left untouched on flush or drain; only ex_o_valid tells EX it is stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg      <= '0;
            insn_reg    <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            rd_reg      <= '0;
            rf_we_reg   <= 1'b0;
            is_load_reg <= 1'b0;
        end else if (accept) begin
            pc_reg      <= bus.id_i_pc;
            insn_reg    <= bus.id_i_insn;
            rs1_reg     <= bus.id_i_rs1;
            rs2_reg     <= bus.id_i_rs2;
            rd_reg      <= bus.id_i_rd;
            rf_we_reg   <= bus.id_i_rf_we;
            is_load_reg <= bus.id_i_is_load;
        end
    end

    always_comb begin
        bus.id_o_ready   = ready;
        bus.ex_o_valid   = full;
        bus.ex_o_pc      = pc_reg;
        bus.ex_o_insn    = insn_reg;
        bus.ex_o_rs1     = rs1_reg;
        bus.ex_o_rs2     = rs2_reg;
        bus.ex_o_rd      = rd_reg;
        bus.ex_o_rf_we   = rf_we_reg;
        bus.ex_o_is_load = is_load_reg;
        bus.ex_o_rs1_dat = ex_src_dat[0];
        bus.ex_o_rs2_dat = ex_src_dat[1];
    end

`ifdef IDEX_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (bus.id_i_valid & hazard & ~bus.flush & (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_reg;
`endif

    a_rst_empties: assert property (@(posedge clk) rst |=> !bus.ex_o_valid);
    a_flush_empties: assert property (@(posedge clk) (!rst && bus.flush) |=> !bus.ex_o_valid);

endmodule

// File: tb/tb_idex_pipe.sv
// Scoreboard bench for idex_pipe: directed scenarios, then randomized traffic vs a reference model.
module tb_idex_pipe;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf_we;
        logic        is_load;
        logic [63:0] rs1_dat;
        logic [63:0] rs2_dat;
    } txn_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   txn_no = 0;

    idex_pipe_if bus_if ();

`ifdef IDEX_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    idex_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
`ifdef IDEX_STALL_CNT_EN
        ,
        .o_stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    txn_t        exp_q [$];
    logic        m_full  = 1'b0;
    logic        m_armed = 1'b0;
    logic        m_zero  = 1'b0;
    txn_t        m_held  = '0;
    logic [31:0] m_cnt   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one instruction slot, advanced once per cycle from the sampled inputs.
    always @(negedge clk) begin
        logic haz;
        logic rdy;
        txn_t cur;
        haz = m_full && m_held.is_load && m_held.rf_we && (m_held.rd != 5'd0) &&
              ((bus_if.id_i_rs1_re && bus_if.id_i_rs1 == m_held.rd) ||
               (bus_if.id_i_rs2_re && bus_if.id_i_rs2 == m_held.rd));
        rdy = (!m_full || bus_if.ex_i_ready) && !haz && !bus_if.flush;
        if (m_armed) begin
            chk("ex_o_valid", {63'd0, bus_if.ex_o_valid}, {63'd0, m_full});
            chk("id_o_ready", {63'd0, bus_if.id_o_ready}, {63'd0, rdy});
            if (m_zero) begin
                chk("rst_pc", bus_if.ex_o_pc, 64'd0);
                chk("rst_insn", {32'd0, bus_if.ex_o_insn}, 64'd0);
                chk("rst_rd", {59'd0, bus_if.ex_o_rd}, 64'd0);
                chk("rst_rs1_dat", bus_if.ex_o_rs1_dat, 64'd0);
                chk("rst_rs2_dat", bus_if.ex_o_rs2_dat, 64'd0);
            end
`ifdef IDEX_STALL_CNT_EN
            chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt});
`endif
        end
        if (rst) begin
            m_full  = 1'b0;
            m_held  = '0;
            m_cnt   = '0;
            m_zero  = 1'b1;
            m_armed = 1'b1;
            exp_q.delete();
        end else begin
            m_zero = 1'b0;
            if (bus_if.id_i_valid && haz && !bus_if.flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (bus_if.flush) begin
                m_full = 1'b0;
                exp_q.delete();
            end else if (bus_if.id_i_valid && rdy) begin
                cur.pc      = bus_if.id_i_pc;
                cur.insn    = bus_if.id_i_insn;
                cur.rs1     = bus_if.id_i_rs1;
                cur.rs2     = bus_if.id_i_rs2;
                cur.rd      = bus_if.id_i_rd;
                cur.rf_we   = bus_if.id_i_rf_we;
                cur.is_load = bus_if.id_i_is_load;
                cur.rs1_dat = bus_if.id_i_rs1_dat;
                cur.rs2_dat = bus_if.id_i_rs2_dat;
                m_held = cur;
                m_full = 1'b1;
                exp_q.push_back(cur);
            end else if (bus_if.ex_i_ready) begin
                m_full = 1'b0;
            end else if (m_full) begin
                if (bus_if.wb_i_rf_we && bus_if.wb_i_rd != 5'd0 && bus_if.wb_i_rd == m_held.rs1)
                    m_held.rs1_dat = bus_if.wb_i_rd_dat;
                if (bus_if.wb_i_rf_we && bus_if.wb_i_rd != 5'd0 && bus_if.wb_i_rd == m_held.rs2)
                    m_held.rs2_dat = bus_if.wb_i_rd_dat;
                if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = m_held;
            end
        end
    end

    // Monitor: every instruction EX consumes must match the oldest expected entry.
    always @(negedge clk) begin
        txn_t got;
        txn_t exp;
        if (m_armed && !rst && !bus_if.flush && bus_if.ex_o_valid === 1'b1 && bus_if.ex_i_ready) begin
            got.pc      = bus_if.ex_o_pc;
            got.insn    = bus_if.ex_o_insn;
            got.rs1     = bus_if.ex_o_rs1;
            got.rs2     = bus_if.ex_o_rs2;
            got.rd      = bus_if.ex_o_rd;
            got.rf_we   = bus_if.ex_o_rf_we;
            got.is_load = bus_if.ex_o_is_load;
            got.rs1_dat = bus_if.ex_o_rs1_dat;
            got.rs2_dat = bus_if.ex_o_rs2_dat;
            checks++;
            txn_no++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL txn %0d unexpected: got pc=%h, required no instruction", txn_no, got.pc);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL txn %0d: got pc=%h insn=%h rd=%0d rs1_dat=%h rs2_dat=%h, required pc=%h insn=%h rd=%0d rs1_dat=%h rs2_dat=%h",
                             txn_no, got.pc, got.insn, got.rd, got.rs1_dat, got.rs2_dat,
                             exp.pc, exp.insn, exp.rd, exp.rs1_dat, exp.rs2_dat);
                end else begin
                    $display("txn %0d ok: pc=%h rd=%0d rs1_dat=%h rs2_dat=%h",
                             txn_no, got.pc, got.rd, got.rs1_dat, got.rs2_dat);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.id_i_valid  = 1'b0;
        bus_if.id_i_rs1_re = 1'b0;
        bus_if.id_i_rs2_re = 1'b0;
        bus_if.flush       = 1'b0;
        bus_if.wb_i_rf_we  = 1'b0;
        bus_if.ex_i_ready  = 1'b1;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic re1,
                         input logic [4:0] rs2, input logic re2, input logic ld);
        bus_if.id_i_valid   = 1'b1;
        bus_if.id_i_pc      = pc;
        bus_if.id_i_insn    = $urandom;
        bus_if.id_i_rd      = rd;
        bus_if.id_i_rs1     = rs1;
        bus_if.id_i_rs1_re  = re1;
        bus_if.id_i_rs2     = rs2;
        bus_if.id_i_rs2_re  = re2;
        bus_if.id_i_rf_we   = 1'b1;
        bus_if.id_i_is_load = ld;
        bus_if.id_i_rs1_dat = {$urandom, $urandom};
        bus_if.id_i_rs2_dat = {$urandom, $urandom};
    endtask

    initial begin
        rst = 1'b1;
        bus_if.id_i_pc      = '0;
        bus_if.id_i_insn    = '0;
        bus_if.id_i_rs1     = '0;
        bus_if.id_i_rs2     = '0;
        bus_if.id_i_rd      = '0;
        bus_if.id_i_rf_we   = 1'b0;
        bus_if.id_i_is_load = 1'b0;
        bus_if.id_i_rs1_dat = '0;
        bus_if.id_i_rs2_dat = '0;
        bus_if.wb_i_rd      = '0;
        bus_if.wb_i_rd_dat  = '0;
        idle();
        repeat (2) step();
        rst = 1'b0;

        // back-to-back ALU ops, no bubble
        offer(64'h8000_0000, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        chk("b2b_valid0", {63'd0, bus_if.ex_o_valid}, 64'd1);
        chk("b2b_pc0", bus_if.ex_o_pc, 64'h8000_0000);
        offer(64'h8000_0004, 5'd2, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
        step();
        chk("b2b_valid1", {63'd0, bus_if.ex_o_valid}, 64'd1);
        chk("b2b_pc1", bus_if.ex_o_pc, 64'h8000_0004);
        idle();
        step();

        // load-use: exactly one bubble
        rst = 1'b1;
        step();
        rst = 1'b0;
        offer(64'h8000_0100, 5'd5, 5'd1, 1'b0, 5'd1, 1'b0, 1'b1);
        step();
        chk("lu_load_pc", bus_if.ex_o_pc, 64'h8000_0100);
        offer(64'h8000_0104, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        chk("lu_ready_stall", {63'd0, bus_if.id_o_ready}, 64'd0);
        step();
        chk("lu_bubble", {63'd0, bus_if.ex_o_valid}, 64'd0);
        chk("lu_ready_after", {63'd0, bus_if.id_o_ready}, 64'd1);
        step();
        chk("lu_consumer_valid", {63'd0, bus_if.ex_o_valid}, 64'd1);
        chk("lu_consumer_pc", bus_if.ex_o_pc, 64'h8000_0104);
`ifdef IDEX_STALL_CNT_EN
        chk("lu_stall_cnt", {32'd0, stall_cnt}, 64'd1);
`endif

        // load to x0 never stalls
        offer(64'h8000_0200, 5'd0, 5'd1, 1'b0, 5'd1, 1'b0, 1'b1);
        step();
        offer(64'h8000_0204, 5'd7, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1;
        chk("x0_ready", {63'd0, bus_if.id_o_ready}, 64'd1);
        step();
        chk("x0_consumer_pc", bus_if.ex_o_pc, 64'h8000_0204);

        // WB refresh of held rs2
        offer(64'h8000_0300, 5'd8, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);
        step();
        bus_if.id_i_valid  = 1'b0;
        bus_if.ex_i_ready  = 1'b0;
        bus_if.wb_i_rf_we  = 1'b1;
        bus_if.wb_i_rd     = 5'd7;
        bus_if.wb_i_rd_dat = 64'h1234;
        step();
        chk("wb_rs2_c1", bus_if.ex_o_rs2_dat, 64'h1234);
        bus_if.wb_i_rf_we = 1'b0;
        step();
        chk("wb_rs2_c2", bus_if.ex_o_rs2_dat, 64'h1234);
        step();
        chk("wb_rs2_c3", bus_if.ex_o_rs2_dat, 64'h1234);
        bus_if.ex_i_ready = 1'b1;
        step();
        chk("wb_consumed", {63'd0, bus_if.ex_o_valid}, 64'd0);

        // flush with a concurrent offer
        offer(64'h8000_0400, 5'd9, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0);
        step();
        bus_if.ex_i_ready = 1'b0;
        offer(64'h8000_0404, 5'd10, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0);
        bus_if.flush = 1'b1;
        step();
        chk("flush_valid", {63'd0, bus_if.ex_o_valid}, 64'd0);
        chk("flush_pc_kept", bus_if.ex_o_pc, 64'h8000_0400);
        idle();
        step();

        // reset in the middle of a load-use stall
        offer(64'h8000_0500, 5'd5, 5'd1, 1'b0, 5'd1, 1'b0, 1'b1);
        step();
        offer(64'h8000_0504, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        bus_if.ex_i_ready = 1'b0;
        step();
        chk("rst_stall_held_pc", bus_if.ex_o_pc, 64'h8000_0500);
        rst = 1'b1;
        step();
        chk("rst_mid_valid", {63'd0, bus_if.ex_o_valid}, 64'd0);
        chk("rst_mid_pc", bus_if.ex_o_pc, 64'd0);
        chk("rst_mid_rs1_dat", bus_if.ex_o_rs1_dat, 64'd0);
        rst = 1'b0;
        bus_if.ex_i_ready = 1'b1;
        #1;
        chk("rst_mid_ready", {63'd0, bus_if.id_o_ready}, 64'd1);
        step();
        chk("rst_resume_pc", bus_if.ex_o_pc, 64'h8000_0504);

        // randomized traffic with small register numbers to provoke hazards and WB hits
        for (int i = 0; i < 600; i++) begin
            rst               = ($urandom_range(0, 99) == 0);
            bus_if.flush      = ($urandom_range(0, 19) == 0);
            bus_if.ex_i_ready = ($urandom_range(0, 9) < 7);
            bus_if.wb_i_rf_we = $urandom_range(0, 1);
            bus_if.wb_i_rd    = 5'($urandom_range(0, 7));
            bus_if.wb_i_rd_dat = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                offer({$urandom, $urandom}, 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0));
                bus_if.id_i_rf_we = ($urandom_range(0, 3) != 0);
            end else begin
                bus_if.id_i_valid = 1'b0;
            end
            step();
        end

        rst = 1'b0;
        idle();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
